// File: rtl/lut_ram_ctrl_if.sv
// ----------------------------------------------------------------------------
// lut_ram_ctrl_if
//   Requester-side bus of lut_ram_ctrl. Bundles the per-requester request
//   handshake and the shared read-response path.
//
//   req_valid  NUM_REQ           per-requester request valid
//   req_we     NUM_REQ           1 = write, 0 = read
//   req_addr   NUM_REQ x ADDR_W  LUT address per requester
//   req_wdata  NUM_REQ x DATA_W  write data per requester
//   req_ready  NUM_REQ           one-hot grant from the controller
//   rsp_valid  NUM_REQ           one-cycle read-response pulse per requester
//   rsp_rdata  DATA_W            shared read data, valid with any rsp_valid bit
//
//   master: requester side (drives requests)
//   slave : controller side (drives grants and responses)
// ----------------------------------------------------------------------------
interface lut_ram_ctrl_if #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0]             req_we;
    logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0]             rsp_valid;
    logic [DATA_W-1:0]              rsp_rdata;

    modport master (
        output req_valid,
        output req_we,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata
    );

    modport slave (
        input  req_valid,
        input  req_we,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        output rsp_rdata
    );
endinterface

// File: rtl/lut_ram_ctrl.sv
// ----------------------------------------------------------------------------
// lut_ram_ctrl
//   Shares one lut_ram between NUM_REQ requesters. A round-robin arbiter
//   grants at most one read or write per cycle; an init FSM fills every
//   entry with INIT_VALUE after reset (INIT_CLEAR=1) and on a clear_req
//   pulse. This block owns all lut_ram control pins.
//
//   clk        in   clock, all state on the rising edge
//   rst        in   asynchronous active-high reset
//   clear_req  in   pulse: refill the whole LUT with INIT_VALUE
//   init_done  out  high while in RUN (LUT contents valid)
//   req_bus    slave modport of lut_ram_ctrl_if (requests, grants, responses)
//   wr_en      out  lut_ram write enable
//   wr_addr    out  lut_ram write address
//   wr_data    out  lut_ram write data
//   rd_addr    out  lut_ram read address
//   rd_data    in   lut_ram asynchronous read data for rd_addr
// ----------------------------------------------------------------------------
module lut_ram_ctrl #(
    parameter int                 NUM_REQ    = 2,
    parameter int                 INIT_CLEAR = 1,
    parameter int                 ADDR_W     = 6,
    parameter int                 DATA_W     = 32,
    parameter logic [DATA_W-1:0]  INIT_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    output logic              init_done,
    lut_ram_ctrl_if.slave     req_bus,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data
);

    typedef logic [ADDR_W-1:0] lut_addr_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam int DEPTH = 2 ** $bits(lut_addr_t);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_d;
    lut_addr_t          fill_cnt_q;
    lut_addr_t          fill_cnt_d;
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [PTR_W-1:0]   rr_ptr_d;
    lut_addr_t          rd_addr_q;

    // Arbiter results
    logic               arb_found;
    logic [PTR_W-1:0]   arb_idx;
    logic               hi_found;
    logic [PTR_W-1:0]   hi_idx;
    logic [PTR_W-1:0]   any_idx;
    logic [NUM_REQ-1:0] gnt_oh;
    logic               win_we;
    lut_addr_t          win_addr;
    word_t              win_wdata;

    // Datapath control for this cycle
    logic               grant_en;
    logic               rd_fire;
    logic               wr_en_c;
    lut_addr_t          wr_addr_c;
    word_t              wr_data_c;
    lut_addr_t          rd_addr_c;

    // Read-response pipeline register
    logic [NUM_REQ-1:0] rsp_vld_p1;
    word_t              rsp_rdata_p1;

    // ------------------------------------------------------------------------
    // Round-robin pick: the lowest valid index at or above rr_ptr wins; if
    // none exists, the scan wraps and the lowest valid index overall wins.
    // Both searches run downward so the final assignment is the lowest hit.
    // ------------------------------------------------------------------------
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        any_idx  = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_bus.req_valid[j]) begin
                any_idx = PTR_W'(j);
                if (j >= int'(rr_ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = PTR_W'(j);
                end
            end
        end
        arb_found = |req_bus.req_valid;
        arb_idx   = hi_found ? hi_idx : any_idx;
    end

    // One-hot grant and mux of the winner's request fields
    always_comb begin
        gnt_oh    = '0;
        win_we    = 1'b0;
        win_addr  = '0;
        win_wdata = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            gnt_oh[j] = grant_en && (arb_idx == PTR_W'(j));
            if (arb_idx == PTR_W'(j)) begin
                win_we    = req_bus.req_we[j];
                win_addr  = req_bus.req_addr[j];
                win_wdata = req_bus.req_wdata[j];
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state and lut_ram control. Everything is forced idle while
    // rst is high so the control pins show their reset values even though
    // the fill writes themselves are combinational.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        grant_en   = 1'b0;
        rd_fire    = 1'b0;
        wr_en_c    = 1'b0;
        wr_addr_c  = '0;
        wr_data_c  = '0;
        rd_addr_c  = rd_addr_q;

        if (!rst) begin
            case (state_q)
                ST_INIT: begin
                    wr_en_c   = 1'b1;
                    wr_addr_c = fill_cnt_q;
                    wr_data_c = INIT_VALUE;
                    if (fill_cnt_q == lut_addr_t'(DEPTH - 1)) begin
                        state_d    = ST_RUN;
                        fill_cnt_d = '0;
                    end else begin
                        fill_cnt_d = fill_cnt_q + 1'b1;
                    end
                end

                ST_RUN: begin
                    // A clear beats any pending request in the same cycle.
                    if (clear_req) begin
                        state_d = ST_INIT;
                    end else if (arb_found) begin
                        grant_en = 1'b1;
                        rr_ptr_d = (arb_idx == PTR_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                        if (win_we) begin
                            wr_en_c   = 1'b1;
                            wr_addr_c = win_addr;
                            wr_data_c = win_wdata;
                        end else begin
                            rd_fire   = 1'b1;
                            rd_addr_c = win_addr;
                        end
                    end
                end

                default: begin
                    state_d = ST_INIT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
            fill_cnt_q <= '0;
            rr_ptr_q   <= '0;
            rd_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            rd_addr_q  <= rd_addr_c;
        end
    end

    // Stage p0 -> p1: lut_ram read data captured at the grant edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_vld_p1   <= '0;
            rsp_rdata_p1 <= '0;
        end else begin
            rsp_vld_p1 <= rd_fire ? gnt_oh : '0;
            if (rd_fire) begin
                rsp_rdata_p1 <= rd_data;
            end
        end
    end

    assign req_bus.req_ready = gnt_oh;
    assign req_bus.rsp_valid = rsp_vld_p1;
    assign req_bus.rsp_rdata = rsp_rdata_p1;

    assign init_done = (state_q == ST_RUN) && !rst;
    assign wr_en     = wr_en_c;
    assign wr_addr   = wr_addr_c;
    assign wr_data   = wr_data_c;
    assign rd_addr   = rd_addr_c;

endmodule
